// File: rtl/root_child_sequencer.sv
// Root sequencer that launches NUM_CHILD child blocks, either one at a time
// or all together, waits for their completion and reports per-run status
// (completion mask, timeout error and the index of the child that timed out).
module root_child_sequencer #(
  parameter int NUM_CHILD = 5,
  parameter int TIMEOUT_W = 8,
  localparam int IDX_W = ($clog2(NUM_CHILD) < 1) ? 1 : $clog2(NUM_CHILD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 par_mode,
  input  logic [TIMEOUT_W-1:0] timeout_lim,
  output logic [NUM_CHILD-1:0] child_start,
  input  logic [NUM_CHILD-1:0] child_done,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [IDX_W-1:0]     err_idx,
  output logic [NUM_CHILD-1:0] done_mask
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] lim_q, lim_d;
  logic                 par_q, par_d;
  logic                 err_q, err_d;
  logic [IDX_W-1:0]     err_idx_q, err_idx_d;
  logic [NUM_CHILD-1:0] mask_q, mask_d;

  logic [NUM_CHILD-1:0] mask_upd;
  logic [NUM_CHILD-1:0] cur_onehot;
  logic [IDX_W-1:0]     first_zero;
  logic [TIMEOUT_W-1:0] cnt_inc;
  logic                 completed;

  // Helper terms: one-hot of current child, parallel mask update and the
  // lowest child still outstanding after this cycle's update.
  always_comb begin
    cur_onehot = {{(NUM_CHILD-1){1'b0}}, 1'b1} << cur_q;
    mask_upd   = mask_q | child_done;
    cnt_inc    = cnt_q + TIMEOUT_W'(1);
    first_zero = '0;
    for (int unsigned i = NUM_CHILD; i > 0; i--) begin
      if (!mask_upd[i-1]) first_zero = IDX_W'(i - 1);
    end
  end

  // Next-state and output decode; completion is evaluated before the
  // timeout so a same-cycle completion always wins.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cnt_d       = cnt_q;
    lim_d       = lim_q;
    par_d       = par_q;
    err_d       = err_q;
    err_idx_d   = err_idx_q;
    mask_d      = mask_q;
    completed   = 1'b0;
    child_start = '0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_FINISH);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LAUNCH;
          par_d     = par_mode;
          lim_d     = timeout_lim;
          err_d     = 1'b0;
          err_idx_d = '0;
          mask_d    = '0;
          cur_d     = '0;
        end
      end
      S_LAUNCH: begin
        child_start = par_q ? '1 : cur_onehot;
        cnt_d       = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (par_q) begin
          mask_d = mask_upd;
          if (&mask_upd) begin
            completed = 1'b1;
            state_d   = S_FINISH;
          end
        end else if (child_done[cur_q]) begin
          completed      = 1'b1;
          mask_d[cur_q]  = 1'b1;
          if (cur_q == IDX_W'(NUM_CHILD - 1)) begin
            state_d = S_FINISH;
          end else begin
            cur_d   = cur_q + IDX_W'(1);
            state_d = S_LAUNCH;
          end
        end
        if (!completed && (lim_q != '0)) begin
          if (cnt_inc == lim_q) begin
            err_d     = 1'b1;
            err_idx_d = par_q ? first_zero : cur_q;
            state_d   = S_FINISH;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      cnt_q     <= '0;
      lim_q     <= '0;
      par_q     <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      lim_q     <= lim_d;
      par_q     <= par_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      mask_q    <= mask_d;
    end
  end

  assign err       = err_q;
  assign err_idx   = err_idx_q;
  assign done_mask = mask_q;

endmodule

// File: doc/root_child_sequencer.md
ROOT_CHILD_SEQUENCER -- requirements
Module: root_child_sequencer

Interface
REQ-001 Parameter NUM_CHILD, default 5, number of child instances sequenced (>=2).
REQ-002 Parameter TIMEOUT_W, default 8, width of per-child timeout counter and limit.
REQ-003 Derived IDX_W = max(1, clog2(NUM_CHILD)).
REQ-004 Clocking: one clock; reset synchronous, active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  request run; sampled only in IDLE.
REQ-008 par_mode  in  1  1 = launch all children together, 0 = one at a time; captured with start.
REQ-009 timeout_lim  in  TIMEOUT_W  WAIT cycles allowed per launch; 0 = timeout disabled; captured with start.
REQ-010 child_start  out  NUM_CHILD  one-cycle start pulses, bit i to child i.
REQ-011 child_done  in  NUM_CHILD  completion pulse/level from child i.
REQ-012 busy  out  1  high in LAUNCH, WAIT, FINISH.
REQ-013 done  out  1  one-cycle run-complete pulse.
REQ-014 err  out  1  run ended by timeout; held until next accepted start.
REQ-015 err_idx  out  IDX_W  index of timed-out child; held with err.
REQ-016 done_mask  out  NUM_CHILD  children completed this run; held until next accepted start.

Function
REQ-017 FSM states IDLE, LAUNCH, WAIT, FINISH; reset state IDLE.
REQ-018 IDLE: start=1 -> LAUNCH next cycle; capture par_mode, timeout_lim; clear err, err_idx, done_mask; child index cur=0.
REQ-019 LAUNCH (one cycle): sequential -> child_start = one-hot(cur); parallel -> child_start = all ones; timeout counter cnt cleared; -> WAIT.
REQ-020 child_start SHALL be zero in every state other than LAUNCH.
REQ-021 child_done SHALL be sampled only in WAIT; values in other states ignored.
REQ-022 Sequential WAIT: child_done[cur]=1 -> set done_mask[cur]; if cur==NUM_CHILD-1 -> FINISH, else cur++ and -> LAUNCH; other child_done bits ignored.
REQ-023 Parallel WAIT: done_mask |= child_done each cycle; when updated mask is all ones -> FINISH.
REQ-024 Timeout: each WAIT cycle without completion and timeout_lim!=0: if cnt+1==timeout_lim -> err=1, -> FINISH; else cnt++.
REQ-025 Completion and timeout in same cycle: completion wins, no err.
REQ-026 err_idx: sequential = cur; parallel = lowest index with done_mask bit 0 after that cycle's update.
REQ-027 FINISH (one cycle): done=1, busy=1; -> IDLE; start in FINISH ignored.
REQ-028 Latency: start accepted cycle t -> first child_start cycle t+1; final completion cycle w -> done at w+1, busy low at w+2.
REQ-029 start while busy SHALL be ignored, no queuing.
REQ-030 cnt saturation: not reachable beyond timeout_lim-1; timeout_lim=0 -> cnt held 0, WAIT unbounded.

Reset
REQ-031 rst=1 at clock edge -> state IDLE, cur=0, cnt=0; child_start, busy, done, err, err_idx, done_mask all 0 next cycle.
REQ-032 Reset mid-run SHALL abort without further child_start pulses; rst dominates start in same cycle.

Verification
REQ-033 Sequential, NUM_CHILD=5, lim=0, each child done 2 cycles after its start -> child_start 0..4 one-hot in order, done pulse once, done_mask=5'b11111, err=0.
REQ-034 Parallel, child_done bits arrive on separate cycles, last at w -> single child_start=5'b11111 at t+1, done at w+1, done_mask=5'b11111.
REQ-035 Sequential, lim=3, child 2 never done -> FINISH 3 WAIT cycles after its launch, err=1, err_idx=2, done_mask=5'b00011, no child_start[3].
REQ-036 Parallel, lim=4, children 1 and 3 silent -> err=1, err_idx=1, done_mask=5'b10101; child_done[cur] on the 3rd WAIT cycle with lim=3 -> no err.
REQ-037 rst asserted in WAIT during sequential run -> all outputs 0 next cycle; start asserted during busy and FINISH -> ignored, no second run.
